cm0_irq_condition: RTL



---
 rtl/cm0_irq_condition_if.sv | 36 +++
 rtl/cm0_irq_condition.sv | 139 +++++++++++++
 2 files changed

// File: rtl/cm0_irq_condition_if.sv
// ---------------------------------------------------------------------------
// cm0_irq_condition_if
// Signal bundle between the interrupt sources/control and the conditioning
// front-end. The clock and reset stay outside as plain ports.
//   IRQIN   [NUM_IRQ-1:0]  asynchronous interrupt sources, active-high
//   NMIIN                  asynchronous NMI source, active-high
//   IRQMODE [NUM_IRQ-1:0]  0 = level, 1 = rising-edge (quasi-static)
//   IRQCLR  [NUM_IRQ-1:0]  single-cycle clear of pending/overflow (edge only)
//   IRQ     [31:0]         to core IRQ bus, bits >= NUM_IRQ tied 0
//   NMI                    to core NMI
//   IRQOVF  [NUM_IRQ-1:0]  sticky overflow flags
//   ANYREQ                 wake / clock-ungate request
// master = source/control side, slave = conditioning block.
// ---------------------------------------------------------------------------
interface cm0_irq_condition_if #(
    parameter int NUM_IRQ = 32
);
    logic [NUM_IRQ-1:0] IRQIN;
    logic               NMIIN;
    logic [NUM_IRQ-1:0] IRQMODE;
    logic [NUM_IRQ-1:0] IRQCLR;
    logic [31:0]        IRQ;
    logic               NMI;
    logic [NUM_IRQ-1:0] IRQOVF;
    logic               ANYREQ;

    modport master (
        output IRQIN, NMIIN, IRQMODE, IRQCLR,
        input  IRQ, NMI, IRQOVF, ANYREQ
    );

    modport slave (
        input  IRQIN, NMIIN, IRQMODE, IRQCLR,
        output IRQ, NMI, IRQOVF, ANYREQ
    );
endinterface

// File: rtl/cm0_irq_condition.sv
// ---------------------------------------------------------------------------
// cm0_irq_condition
// Interrupt conditioning front-end for the Cortex-M0 integration level.
// Synchronises up to 32 asynchronous IRQ sources and NMI into HCLK, and in
// edge mode latches rising edges into per-channel pending bits with a sticky
// overflow flag.
// Ports:
//   HCLK     system clock, all state on the rising edge
//   HRESETn  asynchronous active-low reset
//   bus      cm0_irq_condition_if.slave (see interface header)
// The NUM_IRQ parameter must match the one the interface was built with.
// ---------------------------------------------------------------------------

// Plain N-flop synchroniser, reset to 0.
module cm0_irq_sync #(
    parameter int STAGES = 2
) (
    input  logic HCLK,
    input  logic HRESETn,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sync;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) sync <= '0;
        else          sync <= {sync[STAGES-2:0], d};
    end

    assign q = sync[STAGES-1];
endmodule

// One interrupt channel: synchroniser, edge detector, pending and overflow.
module cm0_irq_channel #(
    parameter int SYNC_STAGES = 2
) (
    input  logic HCLK,
    input  logic HRESETn,
    input  logic irq_in,
    input  logic mode,
    input  logic clr,
    output logic irq,
    output logic ovf
);
    logic lvl;
    logic lvl_d;
    logic edge_det;
    logic pend;
    logic ovf_q;
    logic pend_nxt;
    logic ovf_nxt;

    cm0_irq_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .d       (irq_in),
        .q       (lvl)
    );

    // lvl_d tracks lvl in both modes, so switching level->edge while the
    // source is high never fabricates an edge.
    assign edge_det = lvl & ~lvl_d;

    always_comb begin
        pend_nxt = pend;
        ovf_nxt  = ovf_q;
        if (!mode) begin
            pend_nxt = 1'b0;
            ovf_nxt  = 1'b0;
        end else begin
            // A set beats a coincident clear so no edge is ever lost.
            if (edge_det)      pend_nxt = 1'b1;
            else if (clr)      pend_nxt = 1'b0;
            // Overflow only when the edge lands on an already pending,
            // uncleared channel; a clear otherwise wipes it.
            if (clr)                  ovf_nxt = 1'b0;
            else if (edge_det & pend) ovf_nxt = 1'b1;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            lvl_d <= 1'b0;
            pend  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            lvl_d <= lvl;
            pend  <= pend_nxt;
            ovf_q <= ovf_nxt;
        end
    end

    assign irq = mode ? pend : lvl;
    assign ovf = ovf_q;
endmodule

module cm0_irq_condition #(
    parameter int NUM_IRQ     = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    cm0_irq_condition_if.slave        bus
);
    logic [31:0]        irq_w;
    logic [NUM_IRQ-1:0] ovf_w;
    logic               nmi_w;

    for (genvar n = 0; n < 32; n++) begin : g_ch
        if (n < NUM_IRQ) begin : g_impl
            cm0_irq_channel #(.SYNC_STAGES(SYNC_STAGES)) u_ch (
                .HCLK    (HCLK),
                .HRESETn (HRESETn),
                .irq_in  (bus.IRQIN[n]),
                .mode    (bus.IRQMODE[n]),
                .clr     (bus.IRQCLR[n]),
                .irq     (irq_w[n]),
                .ovf     (ovf_w[n])
            );
        end else begin : g_tie
            assign irq_w[n] = 1'b0;
        end
    end

    // NMI is level-only: just the synchroniser.
    cm0_irq_sync #(.STAGES(SYNC_STAGES)) u_nmi_sync (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .d       (bus.NMIIN),
        .q       (nmi_w)
    );

    assign bus.IRQ    = irq_w;
    assign bus.NMI    = nmi_w;
    assign bus.IRQOVF = ovf_w;
    // Built only from flop outputs (and the quasi-static mode select), so
    // there is no asynchronous input-to-output path.
    assign bus.ANYREQ = (|irq_w) | nmi_w;
endmodule
